alu_pipe: RTL and testbench



---
 rtl/alu_pipe_if.sv | 21 ++
 rtl/alu_pipe.sv | 163 ++++++++++++++++
 tb/tb_alu_pipe.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake bundle between an ALU issuer (master) and alu_pipe (slave).
interface alu_pipe_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           alu_op;
    logic [WIDTH-1:0]     in1;
    logic [WIDTH-1:0]     in2;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     alu_out;
    logic [2:0]           flags;
    logic [ACC_WIDTH-1:0] acc_out;

    modport master (output in_valid, alu_op, in1, in2, out_ready,
                    input  in_ready, out_valid, alu_out, flags, acc_out);
    modport slave  (input  in_valid, alu_op, in1, in2, out_ready,
                    output in_ready, out_valid, alu_out, flags, acc_out);
endinterface

// File: rtl/alu_pipe.sv
// Pipelined signed ALU (ADD/SUB/MUL/MAC/CLRACC/PASS) with valid/ready on both sides.
// Build macro ALU_SAT_EN: overflowing ADD/SUB/MUL/MAC results and the accumulator saturate.
module alu_pipe #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned ACC_WIDTH   = 2 * WIDTH
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned XW = ACC_WIDTH + 1 - PW;
`ifdef ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_SUB    = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;
    localparam logic [2:0] OP_MAC    = 3'd4;
    localparam logic [2:0] OP_CLRACC = 3'd5;
    localparam logic [2:0] OP_PASS   = 3'd6;
    localparam logic [WIDTH-1:0]     RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic             vld;
        logic [2:0]       op;
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic             neg_true;
        logic [PW-1:0]    prod;
    } slot_t;

    logic                 advance;
    slot_t                front_c;
    slot_t                last_src;
    logic [WIDTH:0]       sum_c;
    logic [WIDTH:0]       dif_c;
    logic [PW-1:0]        prod_c;
    logic [ACC_WIDTH:0]   mac_sum_c;
    logic [ACC_WIDTH-1:0] acc_new_c;
    logic [WIDTH-1:0]     res_c;
    logic                 ovf_c;
    logic                 neg_true_c;
    logic                 beat_c;

    logic                 out_valid_d, out_valid_q;
    logic [WIDTH-1:0]     alu_out_d, alu_out_q;
    logic [2:0]           flags_d, flags_q;
    logic [ACC_WIDTH-1:0] acc_d, acc_q;

    assign advance       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.flags     = flags_q;
    assign bus.acc_out   = acc_q;

    // Stage 1 datapath: wrapped result, overflow and sign of the true result.
    always_comb begin
        sum_c  = {bus.in1[WIDTH-1], bus.in1} + {bus.in2[WIDTH-1], bus.in2};
        dif_c  = {bus.in1[WIDTH-1], bus.in1} - {bus.in2[WIDTH-1], bus.in2};
        prod_c = PW'($signed(bus.in1)) * PW'($signed(bus.in2));
        front_c      = '0;
        front_c.vld  = bus.in_valid;
        front_c.op   = bus.alu_op;
        front_c.prod = prod_c;
        case (bus.alu_op)
            OP_ADD: begin
                front_c.res      = sum_c[WIDTH-1:0];
                front_c.ovf      = sum_c[WIDTH] ^ sum_c[WIDTH-1];
                front_c.neg_true = sum_c[WIDTH];
            end
            OP_SUB: begin
                front_c.res      = dif_c[WIDTH-1:0];
                front_c.ovf      = dif_c[WIDTH] ^ dif_c[WIDTH-1];
                front_c.neg_true = dif_c[WIDTH];
            end
            OP_MUL: begin
                front_c.res      = prod_c[WIDTH-1:0];
                front_c.ovf      = prod_c[PW-1:WIDTH-1] != {(WIDTH+1){prod_c[PW-1]}};
                front_c.neg_true = prod_c[PW-1];
            end
            OP_PASS: front_c.res = bus.in1;
            default: ;
        endcase
    end

    // Delay stages between the compute stage and the output stage.
    generate
        if (PIPE_STAGES == 1) begin : g_direct
            assign last_src = front_c;
        end else begin : g_chain
            slot_t dly_d [PIPE_STAGES-1];
            slot_t dly_q [PIPE_STAGES-1];
            always_comb begin
                dly_d[0] = front_c;
                for (int unsigned i = 1; i < PIPE_STAGES - 1; i++) dly_d[i] = dly_q[i-1];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < PIPE_STAGES - 1; i++) dly_q[i] <= '0;
                end else if (advance) begin
                    dly_q <= dly_d;
                end
            end
            assign last_src = dly_q[PIPE_STAGES-2];
        end
    endgenerate

    // Output stage: accumulator ops are applied here so consecutive MACs chain in order.
    always_comb begin
        mac_sum_c  = {acc_q[ACC_WIDTH-1], acc_q} + {{XW{last_src.prod[PW-1]}}, last_src.prod};
        acc_new_c  = mac_sum_c[ACC_WIDTH-1:0];
        res_c      = last_src.res;
        ovf_c      = last_src.ovf;
        neg_true_c = last_src.neg_true;
        if (last_src.op == OP_MAC) begin
            res_c      = mac_sum_c[WIDTH-1:0];
            ovf_c      = mac_sum_c[ACC_WIDTH] ^ mac_sum_c[ACC_WIDTH-1];
            neg_true_c = mac_sum_c[ACC_WIDTH];
        end
        if (SAT_EN && ovf_c) begin
            res_c = neg_true_c ? RES_MIN : RES_MAX;
            if (last_src.op == OP_MAC) acc_new_c = neg_true_c ? ACC_MIN : ACC_MAX;
        end
        beat_c = last_src.vld &&
                 (last_src.op inside {OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_PASS});

        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        if (advance) begin
            out_valid_d = beat_c;
            if (beat_c) begin
                alu_out_d = res_c;
                flags_d   = {ovf_c, res_c[WIDTH-1], res_c == '0};
            end
            if (last_src.vld && last_src.op == OP_MAC)    acc_d = acc_new_c;
            if (last_src.vld && last_src.op == OP_CLRACC) acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases plus random traffic against an integer-arithmetic model.
// Define ALU_SAT_EN for both bench and RTL to check the saturating build.
module tb_alu_pipe;
    localparam int unsigned W = 16;
    localparam int unsigned P = 2;
    localparam int unsigned A = 2 * W;
`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam longint RLO   = -(longint'(1) <<< (W - 1));
    localparam longint RHI   = (longint'(1) <<< (W - 1)) - 1;
    localparam longint ALO   = -(longint'(1) <<< (A - 1));
    localparam longint AHI   = (longint'(1) <<< (A - 1)) - 1;
    localparam longint ASPAN = longint'(1) <<< A;

    typedef struct { logic [W-1:0] res; logic [2:0] flags; logic [A-1:0] acc; } beat_t;
    typedef struct { logic [2:0] op; logic [W-1:0] a; logic [W-1:0] b; } op_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W), .ACC_WIDTH(A)) bus ();
    alu_pipe #(.WIDTH(W), .PIPE_STAGES(P), .ACC_WIDTH(A)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    beat_t  exp_q[$];
    beat_t  got_q[$];
    op_t    op_q[$];
    longint m_acc;
    bit     ov_hist [64];
    bit     acc_fire;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sval(input logic [W-1:0] x);
        return longint'(x) - (x[W-1] ? (longint'(1) <<< W) : longint'(0));
    endfunction

    function automatic logic [W-1:0] clamp_res(input longint t);
        return (t < 0) ? W'(RLO) : W'(RHI);
    endfunction

    // Reference: exact integer result, then range test, then wrap or clamp.
    task automatic model_op(input op_t o);
        longint t;
        bit ovf;
        logic [W-1:0] r;
        beat_t e;
        case (o.op)
            3'd1: t = sval(o.a) + sval(o.b);
            3'd2: t = sval(o.a) - sval(o.b);
            3'd3: t = sval(o.a) * sval(o.b);
            3'd4: t = m_acc + sval(o.a) * sval(o.b);
            3'd6: t = sval(o.a);
            3'd5: begin m_acc = 0; return; end
            default: return;
        endcase
        if (o.op == 3'd4) begin
            ovf = (t < ALO) || (t > AHI);
            if (SAT && ovf) m_acc = (t < 0) ? ALO : AHI;
            else begin
                m_acc = t & (ASPAN - 1);
                if (m_acc > AHI) m_acc -= ASPAN;
            end
            r = (SAT && ovf) ? clamp_res(t) : W'(m_acc);
        end else begin
            ovf = (t < RLO) || (t > RHI);
            r = (SAT && ovf) ? clamp_res(t) : W'(t);
        end
        e.res   = r;
        e.flags = {ovf, r[W-1], r == '0};
        e.acc   = A'(m_acc);
        exp_q.push_back(e);
    endtask

    // One clock: drive at negedge, sample 1ns later, score any beat and any accept.
    task automatic cycle(input bit v, input op_t o, input bit ordy);
        beat_t e, g;
        @(negedge clk);
        bus.in_valid  = v;
        bus.alu_op    = o.op;
        bus.in1       = o.a;
        bus.in2       = o.b;
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) check("spurious_beat", 64'(bus.out_valid), 64'd0);
            else begin
                e = exp_q[0];
                check("alu_out", bus.alu_out, e.res);
                check("flags", bus.flags, e.flags);
                check("acc_out", bus.acc_out, e.acc);
                if (bus.out_ready) begin
                    g.res = bus.alu_out; g.flags = bus.flags; g.acc = bus.acc_out;
                    got_q.push_back(g);
                    void'(exp_q.pop_front());
                end
            end
        end
        acc_fire = v && bus.in_ready;
        if (acc_fire) model_op(o);
    endtask

    task automatic run(input int stall_lo, input int stall_hi, input int rdy_pct,
                       input int max_cyc, input bit drain);
        op_t o;
        bit v, ordy;
        foreach (ov_hist[i]) ov_hist[i] = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (drain && op_q.size() == 0 && exp_q.size() == 0) break;
            v = (op_q.size() != 0);
            o = '{3'd0, W'(0), W'(0)};
            if (v) o = op_q[0];
            ordy = !(c >= stall_lo && c <= stall_hi) && ($urandom_range(99) < rdy_pct);
            cycle(v, o, ordy);
            if (c < 64) ov_hist[c] = bus.out_valid;
            if (stall_lo >= 0 && c == stall_lo + 1) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            if (acc_fire) void'(op_q.pop_front());
        end
        if (drain) begin
            check("drain_ops", op_q.size(), 0);
            check("drain_beats", exp_q.size(), 0);
        end
    endtask

    task automatic push_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_t o;
        o.op = op; o.a = a; o.b = b;
        op_q.push_back(o);
    endtask

    task automatic single(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] xr, input logic [2:0] xf);
        got_q.delete();
        push_op(op, a, b);
        run(-1, -1, 100, 40, 1'b1);
        check({tag, "_early"}, 64'(ov_hist[P-1]), 64'd0);
        check({tag, "_lat"}, 64'(ov_hist[P]), 64'd1);
        check({tag, "_count"}, got_q.size(), 1);
        if (got_q.size() != 0) begin
            check({tag, "_res"}, got_q[0].res, xr);
            check({tag, "_flags"}, got_q[0].flags, xf);
        end
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return W'(1);
            2: return '1;
            3: return {1'b0, {(W-1){1'b1}}};
            4: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.alu_op = 3'd0; bus.in1 = '0; bus.in2 = '0; bus.out_ready = 1'b1;
        m_acc = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_alu_out", bus.alu_out, 64'd0);
        check("rst_flags", bus.flags, 64'd0);
        check("rst_acc_out", bus.acc_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        single("add_ovf", 3'd1, 16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'h8000, SAT ? 3'b100 : 3'b110);
        single("sub_zero", 3'd2, 16'h0005, 16'h0005, 16'h0000, 3'b001);
        single("sub_neg", 3'd2, 16'h0000, 16'h0001, 16'hFFFF, 3'b010);
        single("mul_ovf", 3'd3, 16'h0100, 16'h0100, SAT ? 16'h7FFF : 16'h0000, SAT ? 3'b100 : 3'b101);
        single("mul_neg", 3'd3, 16'hFFFE, 16'h0003, 16'hFFFA, 3'b010);
        single("pass", 3'd6, 16'h8000, 16'h1234, 16'h8000, 3'b010);

        // CLRACC then back-to-back MACs.
        got_q.delete();
        push_op(3'd5, 16'h0000, 16'h0000);
        push_op(3'd4, 16'h0003, 16'h0004);
        push_op(3'd4, 16'hFFFE, 16'h0005);
        push_op(3'd4, 16'h000A, 16'h000A);
        run(-1, -1, 100, 40, 1'b1);
        check("mac_bubble", 64'(ov_hist[P]), 64'd0);
        check("mac_first", 64'(ov_hist[P+1]), 64'd1);
        check("mac_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("mac_beat0", got_q[0].res, 12);
            check("mac_beat1", got_q[1].res, 2);
            check("mac_beat2", got_q[2].res, 102);
            check("mac_acc2", got_q[2].acc, 102);
        end
        check("mac_acc_final", bus.acc_out, 102);

        // Backpressure while four ADDs are issued.
        got_q.delete();
        push_op(3'd1, 16'h0001, 16'h0002);
        push_op(3'd1, 16'h0003, 16'h0004);
        push_op(3'd1, 16'h0064, 16'hFFCE);
        push_op(3'd1, 16'hFFF9, 16'hFFF8);
        run(2, 5, 100, 60, 1'b1);
        check("stall_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("stall_r0", got_q[0].res, 16'h0003);
            check("stall_r1", got_q[1].res, 16'h0007);
            check("stall_r2", got_q[2].res, 16'h0032);
            check("stall_r3", got_q[3].res, 16'hFFF1);
            check("stall_f3", got_q[3].flags, 3'b010);
        end
        run(-1, -1, 100, 3, 1'b0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) push_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
        run(-1, -1, 70, 3000, 1'b1);
        run(-1, -1, 100, 3, 1'b0);

        // Asynchronous reset with MACs in flight.
        for (int i = 0; i < 8; i++) push_op(3'd4, 16'h0005, 16'h0007);
        run(-1, -1, 100, 4, 1'b0);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_acc_out", bus.acc_out, 64'd0);
        check("mid_rst_alu_out", bus.alu_out, 64'd0);
        exp_q.delete();
        op_q.delete();
        m_acc = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(-1, -1, 100, 6, 1'b0);
        check("post_rst_acc", bus.acc_out, 64'd0);
        single("post_rst_mac", 3'd4, 16'h0002, 16'h0003, 16'h0006, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
